// File: rtl/reset_sequencer_if.sv
// Sequencer <-> downstream-block bundle.
//   soft_req    : 1-clk request to drop all enables and re-run the sequence
//   stage_ack   : per-stage ready level from each block
//   en          : thermometer stage enables, en[0] first
//   all_run     : every stage enabled and acked
//   fault       : retries exhausted
//   fault_stage : stage index that caused the fault
//   retry_cnt   : retries used since last reset/soft_req
// master = sequencer side, slave = blocks / board side.
interface reset_sequencer_if #(
  parameter int STAGES    = 4,
  parameter int RETRY_MAX = 3
);
  localparam int FW = $clog2(STAGES) + 1;
  localparam int RW = $clog2(RETRY_MAX + 1) + 1;

  logic              soft_req;
  logic [STAGES-1:0] stage_ack;
  logic [STAGES-1:0] en;
  logic              all_run;
  logic              fault;
  logic [FW-1:0]     fault_stage;
  logic [RW-1:0]     retry_cnt;

  modport master (input soft_req, stage_ack,
                  output en, all_run, fault, fault_stage, retry_cnt);
  modport slave  (output soft_req, stage_ack,
                  input en, all_run, fault, fault_stage, retry_cnt);
endinterface

// File: rtl/reset_sequencer.sv
// Reset release sequencer: synchronises release of the board reset, then
// enables STAGES downstream blocks one at a time, waiting for each ready ack.
// Ack timeout or ack loss in RUN triggers a full restart; after RETRY_MAX
// restarts the sequencer parks in FAULT until rst or soft_req.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset, clears everything immediately
//   bus  : reset_sequencer_if.master (soft_req, stage_ack in; en, all_run,
//          fault, fault_stage, retry_cnt out, all registered)
module reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int SYNC_LEN    = 2,
  parameter int STAGE_DELAY = 62,
  parameter int ACK_TIMEOUT = 1024,
  parameter int RETRY_MAX   = 3
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.master bus
);
  localparam int FW   = $clog2(STAGES) + 1;
  localparam int RW   = $clog2(RETRY_MAX + 1) + 1;
  localparam int CMAX = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [FW-1:0] K_LAST   = FW'(STAGES - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(RETRY_MAX);

  typedef enum logic [2:0] {S_HOLD, S_DELAY, S_ACK, S_RUN, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [SYNC_LEN-1:0] sync_q;
  logic              rst_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     k_q, k_d;
  logic [STAGES-1:0] en_q, en_d;
  logic              run_q, run_d, fault_q, fault_d;
  logic [FW-1:0]     fstage_q, fstage_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [STAGES-1:0] k_onehot;
  logic              ack_k, lost, fail;
  logic [FW-1:0]     lost_j, fail_j;

  // Release synchroniser: async clear, ones shift in after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_LEN-2:0], 1'b1};
  end
  assign rst_s = sync_q[SYNC_LEN-1];

  // Mask-based select avoids indexing with the wider stage counter.
  assign k_onehot = STAGES'(1) << k_q;
  assign ack_k    = |(bus.stage_ack & k_onehot);

  // Lowest dropped ack wins when several stages lose ready together.
  always_comb begin
    lost   = 1'b0;
    lost_j = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (!bus.stage_ack[j]) begin
        lost   = 1'b1;
        lost_j = FW'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    en_d     = en_q;
    run_d    = run_q;
    fault_d  = fault_q;
    fstage_d = fstage_q;
    retry_d  = retry_q;
    fail     = 1'b0;
    fail_j   = '0;
    if (bus.soft_req && state_q != S_HOLD) begin
      // soft_req outranks timeout, ack loss and ack on the same edge
      state_d = S_DELAY;
      cnt_d   = '0;
      k_d     = '0;
      en_d    = '0;
      run_d   = 1'b0;
      fault_d = 1'b0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_HOLD: if (rst_s) begin
          state_d = S_DELAY;
          cnt_d   = '0;
          k_d     = '0;
        end
        S_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            en_d    = en_q | k_onehot;
            state_d = S_ACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ACK: begin
          if (ack_k) begin
            cnt_d = '0;
            if (k_q == K_LAST) begin
              state_d = S_RUN;
              run_d   = 1'b1;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = S_DELAY;
            end
          end else if (cnt_q == ACK_LAST) begin
            fail   = 1'b1;
            fail_j = k_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: if (lost) begin
          fail   = 1'b1;
          fail_j = lost_j;
        end
        S_FAULT: ;
        default: state_d = S_HOLD;
      endcase
      // Timeout and ack loss share one restart path; all enables drop together.
      if (fail) begin
        en_d  = '0;
        run_d = 1'b0;
        cnt_d = '0;
        k_d   = '0;
        if (retry_q < R_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = S_DELAY;
        end else begin
          state_d  = S_FAULT;
          fault_d  = 1'b1;
          fstage_d = fail_j;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      k_q      <= '0;
      en_q     <= '0;
      run_q    <= 1'b0;
      fault_q  <= 1'b0;
      fstage_q <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      en_q     <= en_d;
      run_q    <= run_d;
      fault_q  <= fault_d;
      fstage_q <= fstage_d;
      retry_q  <= retry_d;
    end
  end

  assign bus.en          = en_q;
  assign bus.all_run     = run_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fstage_q;
  assign bus.retry_cnt   = retry_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (STAGES=4, SYNC_LEN=2, STAGE_DELAY=62,
// ACK_TIMEOUT=16, RETRY_MAX=3). Output changes are logged as events stamped
// with the edge number since rst release; tasks queue expected events and
// compare them in order.
module tb_reset_sequencer;
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  en;
    logic        run;
    logic        fault;
    logic [2:0]  rc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] edge_n;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  cur_ev;
  ev_t  prev_ev = '0;

  reset_sequencer_if #(.STAGES(4), .RETRY_MAX(3)) bus ();

  reset_sequencer #(.STAGES(4), .SYNC_LEN(2), .STAGE_DELAY(62),
                    .ACK_TIMEOUT(16), .RETRY_MAX(3))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // edge_n = N between posedge N and posedge N+1 (edge 1 = first after release)
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_n <= 0;
    else      edge_n <= edge_n + 1;
  end

  assign cur_ev = {edge_n, bus.en, bus.all_run, bus.fault, bus.retry_cnt};

  always @(negedge clk) begin
    if (rst && (cur_ev[8:0] != prev_ev[8:0])) obs_q.push_back(cur_ev);
    prev_ev <= cur_ev;
  end

  function automatic ev_t mk(input int c, input logic [3:0] en, input logic run,
                             input logic fault, input logic [2:0] rc);
    return {32'(c), en, run, fault, rc};
  endfunction

  // Nominal sequence with instant acks, DELAY entered on edge e.
  task automatic push_seq(input int e, input logic [2:0] rc);
    exp_q.push_back(mk(e + 62,  4'h1, 1'b0, 1'b0, rc));
    exp_q.push_back(mk(e + 125, 4'h3, 1'b0, 1'b0, rc));
    exp_q.push_back(mk(e + 188, 4'h7, 1'b0, 1'b0, rc));
    exp_q.push_back(mk(e + 251, 4'hF, 1'b0, 1'b0, rc));
    exp_q.push_back(mk(e + 252, 4'hF, 1'b1, 1'b0, rc));
  endtask

  // Waits (bounded) for the next logged event; all-ones means none arrived.
  task automatic wait_obs(output ev_t o);
    o = '1;
    for (int i = 0; i < 3000; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        return;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    bus.soft_req  = 1'b0;
    bus.stage_ack = 4'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.soft_req = 1'b1;
    @(negedge clk); #1;
    bus.soft_req = 1'b0;
    checks++; if (bus.en !== 4'h0) begin errors++; $display("FAIL reset_en: got %h want 0", bus.en); end
    checks++; if (bus.all_run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", bus.all_run); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    checks++; if (bus.fault_stage !== 3'd0) begin errors++; $display("FAIL reset_fstage: got %0d want 0", bus.fault_stage); end
    checks++; if (bus.retry_cnt !== 3'd0) begin errors++; $display("FAIL reset_rc: got %0d want 0", bus.retry_cnt); end
  endtask

  task automatic test_sequence;
    ev_t e, g;
    bus.stage_ack = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    push_seq(3, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL seq_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
  endtask

  task automatic test_soft_req;
    ev_t e, g;
    int s;
    repeat (10) @(negedge clk);
    bus.soft_req = 1'b1;
    s = int'(edge_n) + 1;
    @(negedge clk);
    bus.soft_req = 1'b0;
    exp_q.push_back(mk(s, 4'h0, 1'b0, 1'b0, 3'd0));
    push_seq(s, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL soft_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
  endtask

  task automatic test_ack_loss;
    ev_t e, g;
    int l;
    repeat (10) @(negedge clk);
    bus.stage_ack = 4'b1011;
    l = int'(edge_n) + 1;
    @(negedge clk);
    bus.stage_ack = 4'hF;
    exp_q.push_back(mk(l, 4'h0, 1'b0, 1'b0, 3'd1));
    push_seq(l, 3'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL loss_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
  endtask

  task automatic test_rst_mid_delay;
    ev_t e, g;
    int l;
    // lose stage 0 in RUN so retry_cnt is non-zero, then reset during stage-2 DELAY
    repeat (5) @(negedge clk);
    bus.stage_ack = 4'b1110;
    l = int'(edge_n) + 1;
    @(negedge clk);
    bus.stage_ack = 4'hF;
    exp_q.push_back(mk(l,       4'h0, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(mk(l + 62,  4'h1, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(mk(l + 125, 4'h3, 1'b0, 1'b0, 3'd2));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL rstmid_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.en !== 4'h0) begin errors++; $display("FAIL rstmid_en: got %h want 0", bus.en); end
    checks++; if (bus.all_run !== 1'b0) begin errors++; $display("FAIL rstmid_run: got %b want 0", bus.all_run); end
    checks++; if (bus.retry_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_rc: got %0d want 0", bus.retry_cnt); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_seq(3, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL rstrel_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
  endtask

  task automatic test_timeout_fault;
    ev_t e, g;
    int s;
    // soft_req together with an ack loss in RUN: soft_req must win (rc stays 0)
    repeat (5) @(negedge clk);
    bus.stage_ack = 4'b1101;
    bus.soft_req  = 1'b1;
    s = int'(edge_n) + 1;
    @(negedge clk);
    bus.soft_req = 1'b0;
    exp_q.push_back(mk(s, 4'h0, 1'b0, 1'b0, 3'd0));
    for (int r = 1; r <= 4; r++) begin
      exp_q.push_back(mk(s + 62,  4'h1, 1'b0, 1'b0, 3'(r - 1)));
      exp_q.push_back(mk(s + 125, 4'h3, 1'b0, 1'b0, 3'(r - 1)));
      if (r <= 3) exp_q.push_back(mk(s + 141, 4'h0, 1'b0, 1'b0, 3'(r)));
      else        exp_q.push_back(mk(s + 141, 4'h0, 1'b0, 1'b1, 3'd3));
      s = s + 141;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL tmo_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
    checks++; if (bus.fault_stage !== 3'd1) begin errors++; $display("FAIL tmo_fstage: got %0d want 1", bus.fault_stage); end
    repeat (60) @(negedge clk);
    #1;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL fault_hold: got %0d events want 0", obs_q.size()); end
    checks++; if (bus.fault !== 1'b1 || bus.en !== 4'h0) begin errors++; $display("FAIL fault_out: got fault=%b en=%h want 1/0", bus.fault, bus.en); end
  endtask

  task automatic test_soft_vs_timeout;
    ev_t e, g;
    int s, t;
    @(negedge clk);
    bus.soft_req = 1'b1;
    s = int'(edge_n) + 1;
    @(negedge clk);
    bus.soft_req = 1'b0;
    exp_q.push_back(mk(s, 4'h0, 1'b0, 1'b0, 3'd0));
    for (int r = 1; r <= 3; r++) begin
      exp_q.push_back(mk(s + 62,  4'h1, 1'b0, 1'b0, 3'(r - 1)));
      exp_q.push_back(mk(s + 125, 4'h3, 1'b0, 1'b0, 3'(r - 1)));
      exp_q.push_back(mk(s + 141, 4'h0, 1'b0, 1'b0, 3'(r)));
      s = s + 141;
    end
    exp_q.push_back(mk(s + 62,  4'h1, 1'b0, 1'b0, 3'd3));
    exp_q.push_back(mk(s + 125, 4'h3, 1'b0, 1'b0, 3'd3));
    t = s + 141;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL svt_pre_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
    for (int i = 0; i < 500 && int'(edge_n) != t - 1; i++) @(negedge clk);
    checks++; if (int'(edge_n) != t - 1) begin errors++; $display("FAIL svt_align: got edge %0d want %0d", edge_n, t - 1); end
    bus.soft_req = 1'b1;
    @(negedge clk);
    bus.soft_req  = 1'b0;
    bus.stage_ack = 4'hF;
    exp_q.push_back(mk(t, 4'h0, 1'b0, 1'b0, 3'd0));
    push_seq(t, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); wait_obs(g); checks++;
      if (g !== e) begin errors++; $display("FAIL svt_ev: got cyc=%0d en=%h run=%b flt=%b rc=%0d want cyc=%0d en=%h run=%b flt=%b rc=%0d", g.cyc, g.en, g.run, g.fault, g.rc, e.cyc, e.en, e.run, e.fault, e.rc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_soft_req();
    test_ack_loss();
    test_rst_mid_delay();
    test_timeout_fault();
    test_soft_vs_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
